// File: rtl/countdown_timer.sv
// Programmable one-shot / periodic down-counter timer with a registered one-cycle
// done pulse on expiry and optional auto-reload of the captured start value.
module countdown_timer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] load_val,
  input  logic         auto_reload,
  input  logic         abort,
  output logic [N-1:0] count,
  output logic         busy,
  output logic         done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] count_q, count_d;
  logic [N-1:0] reload_q, reload_d;
  logic         done_q, done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  // Handshake: start is a request with no back-pressure signal; it is accepted
  // only on an edge where the timer is idle and abort is low, and is silently
  // dropped otherwise. busy low is the indication that a start will be taken.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!abort && start) begin
          if (load_val != '0) begin
            state_d  = RUN;
            count_d  = load_val;
            reload_d = load_val;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          count_d = '0;
        end else if (count_q == N'(1)) begin
          done_d = 1'b1;
          if (auto_reload) begin
            count_d = reload_q;
          end else begin
            state_d = IDLE;
            count_d = '0;
          end
        end else begin
          // count is never 0 in RUN, so this cannot wrap
          count_d = count_q - N'(1);
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  assign count = count_q;
  assign busy  = (state_q == RUN);
  assign done  = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus randomized traffic, checked
// against an elapsed-time reference model through an expected-value queue.
module tb_countdown_timer;

  localparam int N = 4;
  localparam int W = N + 2;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] load_val;
  logic         auto_reload;
  logic         abort;
  logic [N-1:0] count;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] exp_q[$];

  // reference model state: running flag, period length, cycles elapsed since start
  bit m_run;
  int m_len;
  int m_el;
  bit m_done;

  countdown_timer #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .load_val    (load_val),
    .auto_reload (auto_reload),
    .abort       (abort),
    .count       (count),
    .busy        (busy),
    .done        (done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_run  = 1'b0;
    m_len  = 0;
    m_el   = 0;
    m_done = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [N-1:0] model_count();
    if (m_run) return N'(m_len - (m_el % m_len));
    return '0;
  endfunction

  // advance the model by one clock edge using the inputs applied for that edge
  task automatic model_step(input bit s, input int lv, input bit ar, input bit ab);
    m_done = 1'b0;
    if (!m_run) begin
      if (!ab && s) begin
        if (lv != 0) begin
          m_run = 1'b1;
          m_len = lv;
          m_el  = 0;
        end else begin
          m_done = 1'b1;
        end
      end
    end else if (ab) begin
      m_run = 1'b0;
    end else begin
      m_el++;
      if (m_el % m_len == 0) begin
        m_done = 1'b1;
        if (!ar) m_run = 1'b0;
      end
    end
    exp_q.push_back({m_run, m_done, model_count()});
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit s, input int lv, input bit ar, input bit ab);
    logic [W-1:0] e;
    @(negedge clk);
    start       = s;
    load_val    = N'(lv);
    auto_reload = ar;
    abort       = ab;
    model_step(s, lv, ar, ab);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("count", 32'(count), 32'(e[N-1:0]));
    check("busy",  32'(busy),  32'(e[W-1]));
    check("done",  32'(done),  32'(e[N]));
  endtask

  task automatic idle_steps(input int n, input bit ar);
    for (int i = 0; i < n; i++) step(1'b0, 0, ar, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    bit seen;
    rst = 1'b0; start = 1'b0; load_val = '0; auto_reload = 1'b0; abort = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    @(negedge clk);
    rst = 1'b1;

    // one-shot L=3
    step(1'b1, 3, 1'b0, 1'b0);
    check("os_first", 32'(count), 32'd3);
    idle_steps(3, 1'b0);
    check("os_end_done", 32'(done), 32'd1);
    idle_steps(2, 1'b0);

    // zero-length timer
    step(1'b1, 0, 1'b0, 1'b0);
    check("zero_done", 32'(done), 32'd1);
    idle_steps(2, 1'b0);

    // periodic L=2, then stop
    step(1'b1, 2, 1'b1, 1'b0);
    idle_steps(5, 1'b1);
    idle_steps(2, 1'b0);

    // back-to-back start in the done cycle
    step(1'b1, 1, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 2, 1'b0, 1'b0);
    idle_steps(3, 1'b0);

    // abort at count=3, then abort+start together in IDLE
    step(1'b1, 5, 1'b0, 1'b0);
    idle_steps(2, 1'b0);
    check("abort_pre", 32'(count), 32'd3);
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b1, 7, 1'b0, 1'b1);
    idle_steps(2, 1'b0);

    // max period with start pulses mid-run; count cycles to done, bounded
    step(1'b1, 15, 1'b0, 1'b0);
    cyc  = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(i % 3 == 0, 9, 1'b0, 1'b0);
      cyc++;
      if (done) seen = 1'b1;
    end
    check("max_period", 32'(cyc), 32'd15);
    idle_steps(2, 1'b0);

    // asynchronous reset in the middle of a count
    step(1'b1, 9, 1'b1, 1'b0);
    idle_steps(3, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("arst_count", 32'(count), 32'd0);
    check("arst_busy",  32'(busy),  32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle_steps(2, 1'b0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 3, int'($urandom_range(0, 15)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
